// File: rtl/arbitro_barrera.sv
// arbitro_barrera
// ---------------
// Single-lane barrier arbiter for the parking lot. One barrier serves both directions:
// entry and exit requests compete for the lane, the winner gets a one-cycle grant pulse,
// and the barrier motor is sequenced open -> pass -> close. The pass is detected by
// watching the occupancy count from the occupancy FSM move away from the value latched
// at grant time.
//
// Build option:
//   ARBITRO_ROUND_ROBIN_EN  defined   : simultaneous entry/exit conflicts alternate
//                                       (side not served last wins, exit first after reset)
//                           undefined : exit always wins conflicts (lot drains first)
//
// Parameters:
//   CAPACITY        maximum occupancy; entry refused when cantidad >= CAPACITY
//   MOVE_CYCLES     cycles the motor is driven to open or close the barrier
//   TIMEOUT_CYCLES  cycles the barrier may stay open without a count change
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   req_in           entry request (level, held until granted)
//   req_out          exit request (level, held until granted)
//   cantidad[2:0]    current occupancy
//   grant_in         one-cycle pulse, lane granted to entry
//   grant_out        one-cycle pulse, lane granted to exit
//   motor_abrir      drive barrier open
//   motor_cerrar     drive barrier closed
//   barrera_abierta  barrier fully open
//   sentido          direction of current/last grant (0 entry, 1 exit)
//   lleno            registered cantidad >= CAPACITY
//   timeout          one-cycle pulse when the open phase ends by timeout
//   err_sentido      one-cycle pulse when the count moved against the granted direction
//
// All outputs are registered.

module arbitro_barrera #(
  parameter int unsigned CAPACITY       = 7,
  parameter int unsigned MOVE_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_in,
  input  logic       req_out,
  input  logic [2:0] cantidad,
  output logic       grant_in,
  output logic       grant_out,
  output logic       motor_abrir,
  output logic       motor_cerrar,
  output logic       barrera_abierta,
  output logic       sentido,
  output logic       lleno,
  output logic       timeout,
  output logic       err_sentido
);

  localparam int unsigned MaxCycles = (MOVE_CYCLES > TIMEOUT_CYCLES) ? MOVE_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned TimerW    = $clog2(MaxCycles) + 1;

  localparam logic [TimerW-1:0] MoveLast    = TimerW'(MOVE_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerOne    = TimerW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StOpening,
    StOpen,
    StClosing
  } state_e;

  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic [2:0]        cnt_ref_q;

  logic              full_now;
  logic              elig_in;
  logic              elig_out;
  logic              pick_in;
  logic              pick_out;
  logic              count_moved;
  logic              count_matched;
  logic [TimerW-1:0] timer_inc;

  assign full_now = ({29'd0, cantidad} >= 32'(CAPACITY));

  // Entry looks at the registered full flag, so it lags cantidad by one cycle.
  assign elig_in  = req_in && !lleno;
  assign elig_out = req_out && (cantidad != 3'd0);

`ifdef ARBITRO_ROUND_ROBIN_EN
  // 1: exit wins the next conflict. Flips to the other side on every grant.
  logic rr_exit_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_exit_q <= 1'b1;
    end else if ((state_q == StIdle) && (pick_in || pick_out)) begin
      rr_exit_q <= pick_in;
    end
  end

  assign pick_out = elig_out && (!elig_in || rr_exit_q);
`else
  assign pick_out = elig_out;
`endif

  assign pick_in = elig_in && !pick_out;

  // A pass is +1 for entry or -1 for exit. Wrap-around (7->0 or 0->7) is a change but
  // never a matched pass, hence the explicit end-of-range exclusions.
  assign count_moved   = (cantidad != cnt_ref_q);
  assign count_matched = sentido ? ((cnt_ref_q != 3'd0) && (cantidad == cnt_ref_q - 3'd1))
                                 : ((cnt_ref_q != 3'd7) && (cantidad == cnt_ref_q + 3'd1));

  // Saturating increment, the timer never wraps.
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TimerOne;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      timer_q         <= '0;
      cnt_ref_q       <= 3'd0;
      grant_in        <= 1'b0;
      grant_out       <= 1'b0;
      motor_abrir     <= 1'b0;
      motor_cerrar    <= 1'b0;
      barrera_abierta <= 1'b0;
      sentido         <= 1'b0;
      lleno           <= 1'b0;
      timeout         <= 1'b0;
      err_sentido     <= 1'b0;
    end else begin
      lleno       <= full_now;
      grant_in    <= 1'b0;
      grant_out   <= 1'b0;
      timeout     <= 1'b0;
      err_sentido <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (pick_in || pick_out) begin
            grant_in    <= pick_in;
            grant_out   <= pick_out;
            sentido     <= pick_out;
            cnt_ref_q   <= cantidad;
            timer_q     <= '0;
            motor_abrir <= 1'b1;
            state_q     <= StOpening;
          end
        end

        StOpening: begin
          if (timer_q == MoveLast) begin
            motor_abrir     <= 1'b0;
            barrera_abierta <= 1'b1;
            timer_q         <= '0;
            state_q         <= StOpen;
          end else begin
            timer_q <= timer_inc;
          end
        end

        StOpen: begin
          // A count change takes priority over a timeout landing on the same cycle.
          if (count_moved || (timer_q == TimeoutLast)) begin
            err_sentido     <= count_moved && !count_matched;
            timeout         <= !count_moved;
            barrera_abierta <= 1'b0;
            motor_cerrar    <= 1'b1;
            timer_q         <= '0;
            state_q         <= StClosing;
          end else begin
            timer_q <= timer_inc;
          end
        end

        StClosing: begin
          if (timer_q == MoveLast) begin
            motor_cerrar <= 1'b0;
            timer_q      <= '0;
            state_q      <= StIdle;
          end else begin
            timer_q <= timer_inc;
          end
        end

        default: begin
          motor_abrir     <= 1'b0;
          motor_cerrar    <= 1'b0;
          barrera_abierta <= 1'b0;
          timer_q         <= '0;
          state_q         <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_barrera.sv
// Randomized bench for arbitro_barrera. The reference model tracks each lane transaction
// as timestamps (grant cycle, close cycle) and derives every expected output from cycle
// arithmetic on those timestamps.

module tb_arbitro_barrera;

  localparam int unsigned Cap  = 7;
  localparam int unsigned Move = 4;
  localparam int unsigned Tmo  = 50;
  localparam int          Inf  = 1 << 29;
  localparam int          Iter = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_in;
  logic       req_out;
  logic [2:0] cantidad;
  logic       grant_in;
  logic       grant_out;
  logic       motor_abrir;
  logic       motor_cerrar;
  logic       barrera_abierta;
  logic       sentido;
  logic       lleno;
  logic       timeout;
  logic       err_sentido;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cyc counts rising edges; values below describe the state right after edge cyc.
  int         cyc;
  int         g_cyc;      // edge at which the last grant was issued
  int         close_cyc;  // edge at which closing began (Inf while not yet decided)
  int         d_chg;      // edges after the barrier opens at which the driver moves cantidad
  bit         m_lleno;
  bit         m_sentido;
  bit         m_rr_exit;
  bit         ev_timeout;
  bit         ev_err;
  logic [2:0] m_ref;

  arbitro_barrera #(
    .CAPACITY       (Cap),
    .MOVE_CYCLES    (Move),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_in          (req_in),
    .req_out         (req_out),
    .cantidad        (cantidad),
    .grant_in        (grant_in),
    .grant_out       (grant_out),
    .motor_abrir     (motor_abrir),
    .motor_cerrar    (motor_cerrar),
    .barrera_abierta (barrera_abierta),
    .sentido         (sentido),
    .lleno           (lleno),
    .timeout         (timeout),
    .err_sentido     (err_sentido)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".grant_in"},        32'(grant_in),        32'd0);
    check({tag, ".grant_out"},       32'(grant_out),       32'd0);
    check({tag, ".motor_abrir"},     32'(motor_abrir),     32'd0);
    check({tag, ".motor_cerrar"},    32'(motor_cerrar),    32'd0);
    check({tag, ".barrera_abierta"}, 32'(barrera_abierta), 32'd0);
    check({tag, ".sentido"},         32'(sentido),         32'd0);
    check({tag, ".lleno"},           32'(lleno),           32'd0);
    check({tag, ".timeout"},         32'(timeout),         32'd0);
    check({tag, ".err_sentido"},     32'(err_sentido),     32'd0);
  endtask

  task automatic model_reset();
    g_cyc     = -1000;
    close_cyc = -1000;
    d_chg     = 1;
    m_lleno   = 1'b0;
    m_sentido = 1'b0;
    m_rr_exit = 1'b1;
    m_ref     = 3'd0;
    ev_timeout = 1'b0;
    ev_err     = 1'b0;
  endtask

  // Advance the model across edge c using the inputs present just before that edge.
  task automatic model_step(input int c);
    bit e_in;
    bit e_out;
    bit pick_out;
    int diff;
    ev_timeout = 1'b0;
    ev_err     = 1'b0;
    if (c > close_cyc + int'(Move)) begin
      e_in  = req_in && !m_lleno;
      e_out = req_out && (cantidad != 3'd0);
      if (e_in || e_out) begin
        pick_out  = e_out && (!e_in || m_rr_exit);
`ifdef ARBITRO_ROUND_ROBIN_EN
        m_rr_exit = !pick_out;
`endif
        g_cyc     = c;
        close_cyc = Inf;
        m_sentido = pick_out;
        m_ref     = cantidad;
      end
    end else if ((close_cyc == Inf) && (c - 1 >= g_cyc + int'(Move))) begin
      if (cantidad != m_ref) begin
        diff      = int'(cantidad) - int'(m_ref);
        ev_err    = (diff != (m_sentido ? -1 : 1));
        close_cyc = c;
      end else if (c - (g_cyc + int'(Move)) == int'(Tmo)) begin
        ev_timeout = 1'b1;
        close_cyc  = c;
      end
    end
    m_lleno = (int'(cantidad) >= int'(Cap));
  endtask

  task automatic check_outputs();
    int c = cyc;
    check("grant_in",        32'(grant_in),        32'((g_cyc == c) && !m_sentido));
    check("grant_out",       32'(grant_out),       32'((g_cyc == c) && m_sentido));
    check("motor_abrir",     32'(motor_abrir),     32'((c >= g_cyc) && (c < g_cyc + int'(Move))));
    check("barrera_abierta", 32'(barrera_abierta),
          32'((c >= g_cyc + int'(Move)) && (c < close_cyc)));
    check("motor_cerrar",    32'(motor_cerrar),
          32'((c >= close_cyc) && (c < close_cyc + int'(Move))));
    check("sentido",         32'(sentido),         32'(m_sentido));
    check("lleno",           32'(lleno),           32'(m_lleno));
    check("timeout",         32'(timeout),         32'(ev_timeout));
    check("err_sentido",     32'(err_sentido),     32'(ev_err));
  endtask

  // Drive inputs for the upcoming edge cyc+1.
  task automatic drive();
    int n = cyc + 1;
    if (g_cyc == cyc) begin
      if (m_sentido) req_out = 1'b0;
      else           req_in  = 1'b0;
      case ($urandom_range(0, 7))
        0:       d_chg = int'(Tmo);       // change lands on the timeout cycle
        1:       d_chg = int'(Tmo) + 10;  // barrier times out first
        default: d_chg = int'($urandom_range(1, 20));
      endcase
    end
    if (!req_in  && ($urandom_range(0, 3) == 0)) req_in  = 1'b1;
    if (!req_out && ($urandom_range(0, 3) == 0)) req_out = 1'b1;
    if (close_cyc == Inf) begin
      if (n == g_cyc + int'(Move) + d_chg) begin
        if ($urandom_range(0, 4) != 0) cantidad = m_sentido ? cantidad - 3'd1 : cantidad + 3'd1;
        else                           cantidad = cantidad + 3'($urandom_range(2, 6));
      end
    end else if ((cyc >= close_cyc + int'(Move)) && ($urandom_range(0, 9) == 0)) begin
      cantidad = 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    reset    = 1'b0;
    req_in   = 1'b1;
    req_out  = 1'b0;
    cantidad = 3'd0;
    cyc      = 0;
    model_reset();

    // Held in reset with a pending entry request: nothing may move.
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end

    for (int i = 0; i < Iter; i++) begin
      @(negedge clk);
      if (i == 0) begin
        reset = 1'b1;
      end else begin
        // Occasional reset while the barrier is in motion or open.
        if ((cyc >= g_cyc) && (cyc < close_cyc + int'(Move)) && ($urandom_range(0, 199) == 0)) begin
          #2 reset = 1'b0;
          #1 check_zero("rst_async");
          if (m_sentido) req_out = 1'b1;
          else           req_in  = 1'b1;
          model_reset();
          @(posedge clk);
          cyc++;
          #1 check_zero("rst_held");
          @(negedge clk);
          reset = 1'b1;
        end
        drive();
      end
      @(posedge clk);
      cyc++;
      model_step(cyc);
      #1;
      check_outputs();
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
